// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_unit
// Purpose  : Multicycle RV32I control FSM plus ALU decoder. Decodes the
//            instruction held in the IR and sequences the shared datapath
//            for lw, sw, R-type (add/sub/and/or/slt), I-type ALU, beq, jal.
// Ports    : clk, rst (async, active-high)
//            op[6:0], funct3[2:0], funct7b5   - instruction fields from IR
//            zero                             - ALU result == 0 flag
//            pc_write, adr_src, mem_write, ir_write, reg_write
//            result_src[1:0], alu_src_a[1:0], alu_src_b[1:0], imm_src[1:0]
//            alu_control[2:0]                 - ALU operation select
//            illegal_instr                    - only with ILLEGAL_TRAP_EN
//            state_o[STATE_W-1:0]             - current state (debug)
// Config   : `define ILLEGAL_TRAP_EN to trap unsupported opcodes in a
//            terminal ILLEGAL state; otherwise they execute as a nop.
// Revision : 1.0 - initial release
// ============================================================================
module mc_control_unit #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         imm_src,
  output logic               reg_write,
  output logic [2:0]         alu_control,
`ifdef ILLEGAL_TRAP_EN
  output logic               illegal_instr,
`endif
  output logic [STATE_W-1:0] state_o
);

  // State encoding
  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXECR    = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_EXECI    = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_BEQ      = STATE_W'(10);
`ifdef ILLEGAL_TRAP_EN
  localparam logic [STATE_W-1:0] S_ILLEGAL  = STATE_W'(11);
`endif

  // Opcodes
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [1:0]         alu_op;
  logic               pc_update;
  logic               branch;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
`ifdef ILLEGAL_TRAP_EN
          default:      state_d = S_ILLEGAL;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      // Only lw and sw reach MEMADR, so anything not lw is a store.
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_ILLEGAL:  state_d = S_ILLEGAL;
`endif
      // Unreachable encodings recover to FETCH.
      default:    state_d = S_FETCH;
    endcase
  end

  // --------------------------------------------------------------------------
  // Moore outputs
  // --------------------------------------------------------------------------
  always_comb begin
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    reg_write  = 1'b0;
    alu_op     = ALUOP_ADD;
    pc_update  = 1'b0;
    branch     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b10;
        alu_op     = ALUOP_ADD;
        result_src = 2'b10;
        pc_update  = 1'b1;
      end
      S_DECODE: begin
        // Branch target PC_old + imm lands in ALUOut for a possible beq.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        result_src = 2'b00;
        reg_write  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b00;
        alu_op     = ALUOP_SUB;
        result_src = 2'b00;
        branch     = 1'b1;
      end
      S_JAL: begin
        // Return address PC_old + 4 computed here; target already in ALUOut.
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        alu_op     = ALUOP_ADD;
        result_src = 2'b00;
        pc_update  = 1'b1;
      end
      default: begin
        // ILLEGAL and unreachable encodings keep every enable low.
      end
    endcase
    pc_write = pc_update | (branch & zero);
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = (state_q == S_ILLEGAL);
`endif

  // --------------------------------------------------------------------------
  // ALU decoder
  // --------------------------------------------------------------------------
  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      ALUOP_ADD: alu_control = 3'b000;
      ALUOP_SUB: alu_control = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          // op[5] separates R-type from I-type so addi never becomes sub.
          3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  // Immediate format depends only on the opcode.
  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  assign state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_control_unit
// Purpose  : Directed self-checking bench for mc_control_unit. Each task
//            starts and ends in FETCH with time just after a clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_control_unit;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic       reg_write;
  logic [2:0] alu_control;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_instr;
`endif
  logic [3:0] state_o;

  int errors = 0;
  int checks = 0;

  mc_control_unit #(.STATE_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .reg_write   (reg_write),
    .alu_control (alu_control),
`ifdef ILLEGAL_TRAP_EN
    .illegal_instr (illegal_instr),
`endif
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] instr);
    op       = instr[6:0];
    funct3   = instr[14:12];
    funct7b5 = instr[30];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_instr(32'h0000_0013);
    zero = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'd0) begin
      errors++; $display("FAIL reset_state got=%0d exp=0", state_o);
    end
    checks++;
    if ({ir_write, pc_write, alu_src_b, result_src} !== 6'b11_10_10) begin
      errors++; $display("FAIL reset_fetch_outs got=%b exp=111010",
                         {ir_write, pc_write, alu_src_b, result_src});
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lw();
    int exp_st[5] = '{0, 1, 2, 3, 4};
    set_instr(32'h0080_A283);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (state_o !== 4'(exp_st[i])) begin
        errors++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, state_o, exp_st[i]);
      end
      checks++;
      if (reg_write !== (exp_st[i] == 4)) begin
        errors++; $display("FAIL lw_reg_write[%0d] got=%b exp=%b", i, reg_write, exp_st[i] == 4);
      end
      checks++;
      if (result_src !== ((exp_st[i] == 4) ? 2'b01 : (exp_st[i] == 0) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL lw_result_src[%0d] got=%b", i, result_src);
      end
      if (exp_st[i] == 3) begin
        checks++;
        if (adr_src !== 1'b1) begin
          errors++; $display("FAIL lw_memread_adr_src got=%b exp=1", adr_src);
        end
      end
      tick();
    end
    checks++;
    if (state_o !== 4'd0) begin
      errors++; $display("FAIL lw_return got=%0d exp=0", state_o);
    end
  endtask

  task automatic test_rtype_itype();
    // sub x3,x1,x2
    set_instr(32'h4020_81B3);
    tick();
    checks++;
    if ({alu_src_a, alu_src_b} !== 4'b0101) begin
      errors++; $display("FAIL decode_srcs got=%b exp=0101", {alu_src_a, alu_src_b});
    end
    tick();
    checks++;
    if (state_o !== 4'd6 || alu_control !== 3'b001 || alu_src_a !== 2'b10 || alu_src_b !== 2'b00) begin
      errors++; $display("FAIL sub_execr got st=%0d alu=%b exp st=6 alu=001", state_o, alu_control);
    end
    tick();
    checks++;
    if (state_o !== 4'd7 || reg_write !== 1'b1 || result_src !== 2'b00) begin
      errors++; $display("FAIL sub_aluwb got st=%0d rw=%b rs=%b", state_o, reg_write, result_src);
    end
    tick();
    // addi with instr[30]=1 stays add
    set_instr(32'h4010_8093);
    tick();
    tick();
    checks++;
    if (state_o !== 4'd8 || alu_control !== 3'b000 || alu_src_b !== 2'b01) begin
      errors++; $display("FAIL addi_execi got st=%0d alu=%b exp st=8 alu=000", state_o, alu_control);
    end
    tick();
    tick();
    // R-type funct3 decode table: slt, or, and, sll(unsupported -> add)
    begin
      logic [2:0] f3[4]  = '{3'b010, 3'b110, 3'b111, 3'b001};
      logic [2:0] exp[4] = '{3'b101, 3'b011, 3'b010, 3'b000};
      for (int i = 0; i < 4; i++) begin
        op = 7'b0110011; funct3 = f3[i]; funct7b5 = 1'b0;
        tick();
        tick();
        checks++;
        if (alu_control !== exp[i]) begin
          errors++; $display("FAIL rtype_f3[%0d] got=%b exp=%b", i, alu_control, exp[i]);
        end
        tick();
        tick();
      end
    end
  endtask

  task automatic test_beq();
    op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0;
    zero = 1'b1;
    tick();
    checks++;
    if (pc_write !== 1'b0) begin
      errors++; $display("FAIL beq_decode_pc_write got=%b exp=0", pc_write);
    end
    tick();
    checks++;
    if (state_o !== 4'd10 || pc_write !== 1'b1 || alu_control !== 3'b001 || imm_src !== 2'b10) begin
      errors++; $display("FAIL beq_taken got st=%0d pcw=%b alu=%b imm=%b", state_o, pc_write, alu_control, imm_src);
    end
    tick();
    checks++;
    if (state_o !== 4'd0) begin
      errors++; $display("FAIL beq_return got=%0d exp=0", state_o);
    end
    zero = 1'b0;
    tick();
    tick();
    checks++;
    if (state_o !== 4'd10 || pc_write !== 1'b0) begin
      errors++; $display("FAIL beq_not_taken got st=%0d pcw=%b exp st=10 pcw=0", state_o, pc_write);
    end
    tick();
  endtask

  task automatic test_sw();
    int wr_cnt = 0;
    set_instr(32'h0020_A423);
    #1;
    checks++;
    if (imm_src !== 2'b01) begin
      errors++; $display("FAIL sw_imm_src got=%b exp=01", imm_src);
    end
    for (int i = 0; i < 4; i++) begin
      if (mem_write === 1'b1) begin
        wr_cnt++;
        checks++;
        if (state_o !== 4'd5 || adr_src !== 1'b1) begin
          errors++; $display("FAIL sw_memwrite got st=%0d adr=%b exp st=5 adr=1", state_o, adr_src);
        end
      end
      tick();
    end
    checks++;
    if (wr_cnt != 1 || state_o !== 4'd0) begin
      errors++; $display("FAIL sw_write_count got=%0d st=%0d exp=1 st=0", wr_cnt, state_o);
    end
  endtask

  task automatic test_jal();
    op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0;
    tick();
    tick();
    checks++;
    if (state_o !== 4'd9 || pc_write !== 1'b1 || alu_src_a !== 2'b01 || alu_src_b !== 2'b10 || imm_src !== 2'b11) begin
      errors++; $display("FAIL jal_state got st=%0d pcw=%b a=%b b=%b imm=%b", state_o, pc_write, alu_src_a, alu_src_b, imm_src);
    end
    tick();
    checks++;
    if (state_o !== 4'd7 || reg_write !== 1'b1) begin
      errors++; $display("FAIL jal_aluwb got st=%0d rw=%b exp st=7 rw=1", state_o, reg_write);
    end
    tick();
  endtask

  task automatic test_illegal();
    op = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0;
    tick();
    tick();
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (state_o !== 4'd11 || illegal_instr !== 1'b1 || pc_write !== 1'b0 || ir_write !== 1'b0) begin
        errors++; $display("FAIL illegal_hold[%0d] got st=%0d ill=%b pcw=%b", i, state_o, illegal_instr, pc_write);
      end
      tick();
    end
    rst = 1'b1;
    #1;
    checks++;
    if (state_o !== 4'd0 || illegal_instr !== 1'b0) begin
      errors++; $display("FAIL illegal_reset got st=%0d ill=%b exp st=0", state_o, illegal_instr);
    end
    @(negedge clk);
    rst = 1'b0;
`else
    checks++;
    if (state_o !== 4'd0) begin
      errors++; $display("FAIL illegal_nop got=%0d exp=0", state_o);
    end
`endif
  endtask

  task automatic test_reset_mid();
    set_instr(32'h0080_A283);
    tick();
    tick();
    tick();
    checks++;
    if (state_o !== 4'd3) begin
      errors++; $display("FAIL mid_pre got=%0d exp=3", state_o);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (state_o !== 4'd0 || ir_write !== 1'b1 || pc_write !== 1'b1 || alu_control !== 3'b000) begin
      errors++; $display("FAIL mid_reset got st=%0d irw=%b pcw=%b alu=%b", state_o, ir_write, pc_write, alu_control);
    end
    tick();
    checks++;
    if (state_o !== 4'd0) begin
      errors++; $display("FAIL mid_reset_hold got=%0d exp=0", state_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype_itype();
    test_beq();
    test_sw();
    test_jal();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
